// File: rtl/csr_ctrl_pkg.sv
// Shared definitions for the machine-mode CSR sequencer: operation codes,
// CSR addresses, FSM state encoding, data width and mcause constants.
// Optional feature macro used by the sequencer: YSYX_23060251_ILLEGAL_CSR_EN.
package csr_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] MCAUSE_ECALL   = 32'd11;
    localparam logic [XLEN-1:0] MCAUSE_ILLEGAL = 32'd2;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // True for the three read-modify-write CSR instructions.
    function automatic logic is_csr_op(input op_e op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

    // True for the op codes the sequencer actually runs; 0, 6 and 7 are no-ops.
    function automatic logic is_active_op(input op_e op);
        return is_csr_op(op) || (op == OP_ECALL) || (op == OP_MRET);
    endfunction

    // CSRs implemented by the attached CSR file.
    function automatic logic csr_known(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational write-data generator for CSRRW / CSRRS / CSRRC.
module csr_alu
    import csr_ctrl_pkg::*;
(
    input  op_e             op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] wdata
);

    // Select new CSR value from the old value and the source operand.
    always_comb begin
        wdata = old;
        case (op)
            OP_CSRRW: wdata = rs1;
            OP_CSRRS: wdata = old | rs1;
            OP_CSRRC: wdata = old & ~rs1;
            default:  wdata = old;
        endcase
    end

endmodule

// File: rtl/csr_ctrl.sv
// Sequencer between execute and the machine-mode CSR file.
// Each accepted instruction runs IDLE -> READ -> WRITE -> RESP -> IDLE.
// Optional macro YSYX_23060251_ILLEGAL_CSR_EN turns CSR ops on unimplemented
// addresses into an illegal-instruction trap; without it they complete with
// no write and rd = 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready_o high, waiting for a request
// S_READ  | csr_addr_o drives the CSR to read; old value captured at exit
// S_WRITE | exactly one of wen/ecall/mret is high (or none for rs1 = x0)
// S_RESP  | valid_o high with rd / redirect, held until ready_i
module csr_ctrl
    import csr_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [11:0]      csr_addr_i,
    input  logic [XLEN-1:0]  rs1_val_i,
    input  logic             rs1_zero_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  csr_rdata_i,
    output logic [11:0]      csr_addr_o,
    output logic [XLEN-1:0]  csr_wdata_o,
    output logic             csr_wen_o,
    output logic             csr_ecall_o,
    output logic             csr_mret_o,
    output logic [XLEN-1:0]  csr_mepc_o,
    output logic [XLEN-1:0]  csr_mcause_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             rd_wen_o,
    output logic [XLEN-1:0]  rd_data_o,
    output logic             redirect_o,
    output logic [XLEN-1:0]  redirect_pc_o
);

    state_e          state;
    op_e             op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] old_q;
    logic            rs1_zero_q;
    logic            known_q;
    logic            illegal_q;
    logic            wen_q;
    logic            ecall_q;
    logic            mret_q;

    op_e             req_op;
    logic            req_go;
    logic            req_illegal;
    logic [11:0]     req_read_addr;
    logic [XLEN-1:0] alu_wdata;

    // The ALU works on the live read data so the write value is ready
    // the cycle after READ without an extra pipeline stage.
    csr_alu u_alu (
        .op    (op_q),
        .old   (csr_rdata_i),
        .rs1   (rs1_q),
        .wdata (alu_wdata)
    );

    // Decode the incoming request: whether to start, whether it traps,
    // and which CSR the READ cycle must present.
    always_comb begin
        req_op        = op_e'(op_i);
        req_go        = valid_i && is_active_op(req_op);
        req_illegal   = 1'b0;
`ifdef YSYX_23060251_ILLEGAL_CSR_EN
        req_illegal   = is_csr_op(req_op) && !csr_known(csr_addr_i);
`endif
        req_read_addr = csr_addr_i;
        if (req_illegal || (req_op == OP_ECALL)) begin
            req_read_addr = CSR_MTVEC;
        end else if (req_op == OP_MRET) begin
            req_read_addr = CSR_MEPC;
        end
    end

    // Strobes drop immediately under reset so an aborted WRITE issues nothing.
    assign csr_wen_o   = wen_q   & ~rst_i;
    assign csr_ecall_o = ecall_q & ~rst_i;
    assign csr_mret_o  = mret_q  & ~rst_i;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            op_q          <= OP_NONE;
            rs1_q         <= '0;
            pc_q          <= '0;
            old_q         <= '0;
            rs1_zero_q    <= 1'b0;
            known_q       <= 1'b0;
            illegal_q     <= 1'b0;
            wen_q         <= 1'b0;
            ecall_q       <= 1'b0;
            mret_q        <= 1'b0;
            ready_o       <= 1'b1;
            csr_addr_o    <= '0;
            csr_wdata_o   <= '0;
            csr_mepc_o    <= '0;
            csr_mcause_o  <= '0;
            valid_o       <= 1'b0;
            rd_wen_o      <= 1'b0;
            rd_data_o     <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_go) begin
                        op_q       <= req_op;
                        rs1_q      <= rs1_val_i;
                        pc_q       <= pc_i;
                        rs1_zero_q <= rs1_zero_i;
                        known_q    <= csr_known(csr_addr_i);
                        illegal_q  <= req_illegal;
                        csr_addr_o <= req_read_addr;
                        ready_o    <= 1'b0;
                        state      <= S_READ;
                    end
                end
                S_READ: begin
                    old_q <= csr_rdata_i;
                    if (illegal_q) begin
                        ecall_q      <= 1'b1;
                        csr_mepc_o   <= pc_q;
                        csr_mcause_o <= MCAUSE_ILLEGAL;
                    end else begin
                        case (op_q)
                            OP_CSRRW: begin
                                wen_q       <= known_q;
                                csr_wdata_o <= alu_wdata;
                            end
                            OP_CSRRS, OP_CSRRC: begin
                                wen_q       <= known_q && !rs1_zero_q;
                                csr_wdata_o <= alu_wdata;
                            end
                            OP_ECALL: begin
                                ecall_q      <= 1'b1;
                                csr_mepc_o   <= pc_q;
                                csr_mcause_o <= MCAUSE_ECALL;
                            end
                            OP_MRET: mret_q <= 1'b1;
                            default: ;
                        endcase
                    end
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    wen_q   <= 1'b0;
                    ecall_q <= 1'b0;
                    mret_q  <= 1'b0;
                    valid_o <= 1'b1;
                    if (illegal_q || !is_csr_op(op_q)) begin
                        rd_wen_o      <= 1'b0;
                        redirect_o    <= 1'b1;
                        redirect_pc_o <= old_q;
                    end else begin
                        rd_wen_o   <= 1'b1;
                        rd_data_o  <= old_q;
                        redirect_o <= 1'b0;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (ready_i) begin
                        valid_o    <= 1'b0;
                        rd_wen_o   <= 1'b0;
                        redirect_o <= 1'b0;
                        ready_o    <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench for csr_ctrl with a small behavioural CSR file.
module tb_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] rs1_val_i;
    logic        rs1_zero_i;
    logic [31:0] pc_i;
    logic [31:0] csr_rdata_i;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_wen_o;
    logic        csr_ecall_o;
    logic        csr_mret_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mcause_o;
    logic        valid_o;
    logic        ready_i;
    logic        rd_wen_o;
    logic [31:0] rd_data_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    // captured per sequence
    logic        c_ready_acc, c_ready_rd, c_strobe_rd;
    logic [11:0] c_rd_addr;
    logic        c_wen, c_ecall, c_mret;
    logic [31:0] c_wdata, c_mepc, c_mcause;
    logic        c_valid, c_rd_wen, c_redirect, c_strobe_resp;
    logic [31:0] c_rd_data, c_redirect_pc;
    logic        c_valid_after, c_ready_after;

    always #5 clk = ~clk;

    always_comb begin
        case (csr_addr_o)
            12'h300: csr_rdata_i = m_mstatus;
            12'h305: csr_rdata_i = m_mtvec;
            12'h341: csr_rdata_i = m_mepc;
            12'h342: csr_rdata_i = m_mcause;
            default: csr_rdata_i = 32'h0;
        endcase
    end

    csr_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .csr_addr_i(csr_addr_i), .rs1_val_i(rs1_val_i),
        .rs1_zero_i(rs1_zero_i), .pc_i(pc_i), .csr_rdata_i(csr_rdata_i),
        .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o), .csr_wen_o(csr_wen_o),
        .csr_ecall_o(csr_ecall_o), .csr_mret_o(csr_mret_o), .csr_mepc_o(csr_mepc_o),
        .csr_mcause_o(csr_mcause_o), .valid_o(valid_o), .ready_i(ready_i),
        .rd_wen_o(rd_wen_o), .rd_data_o(rd_data_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the current cycle (N) and capture N+1..N+4.
    task automatic run_req(input logic [2:0] op, input logic [11:0] addr,
                           input logic [31:0] rs1, input logic rz, input logic [31:0] pc);
        valid_i = 1'b1; op_i = op; csr_addr_i = addr;
        rs1_val_i = rs1; rs1_zero_i = rz; pc_i = pc; ready_i = 1'b1;
        c_ready_acc = ready_o;
        step();
        valid_i = 1'b0; op_i = 3'd0;
        c_ready_rd  = ready_o;
        c_rd_addr   = csr_addr_o;
        c_strobe_rd = csr_wen_o | csr_ecall_o | csr_mret_o;
        step();
        c_wen = csr_wen_o; c_ecall = csr_ecall_o; c_mret = csr_mret_o;
        c_wdata = csr_wdata_o; c_mepc = csr_mepc_o; c_mcause = csr_mcause_o;
        step();
        c_valid = valid_o; c_rd_wen = rd_wen_o; c_rd_data = rd_data_o;
        c_redirect = redirect_o; c_redirect_pc = redirect_pc_o;
        c_strobe_resp = csr_wen_o | csr_ecall_o | csr_mret_o;
        step();
        c_valid_after = valid_o; c_ready_after = ready_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b1; op_i = 3'd1; csr_addr_i = 12'h300;
        rs1_val_i = 32'h5; rs1_zero_i = 1'b0; pc_i = 32'h0; ready_i = 1'b1;
        step(); step();
        rst_i = 1'b0; valid_i = 1'b0; op_i = 3'd0;
        checks++;
        if ({valid_o, rd_wen_o, redirect_o, csr_wen_o, csr_ecall_o, csr_mret_o} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp 000000",
                {valid_o, rd_wen_o, redirect_o, csr_wen_o, csr_ecall_o, csr_mret_o});
        end
        checks++;
        if ({csr_addr_o, csr_wdata_o, csr_mepc_o, csr_mcause_o, rd_data_o, redirect_pc_o} !== 172'b0) begin
            errors++; $display("FAIL reset_data: data outputs not all zero");
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b exp 1", ready_o);
        end
    endtask

    task automatic test_csrrw();
        m_mtvec = 32'h0;
        run_req(3'd1, 12'h305, 32'h8000_0100, 1'b0, 32'h8000_0000);
        checks++;
        if (c_ready_acc !== 1'b1 || c_ready_rd !== 1'b0) begin
            errors++; $display("FAIL rw_ready: got acc=%b rd=%b exp 1/0", c_ready_acc, c_ready_rd);
        end
        checks++;
        if (c_rd_addr !== 12'h305 || c_strobe_rd !== 1'b0) begin
            errors++; $display("FAIL rw_read: got addr=%h strobe=%b exp 305/0", c_rd_addr, c_strobe_rd);
        end
        checks++;
        if ({c_wen, c_ecall, c_mret} !== 3'b100 || c_wdata !== 32'h8000_0100) begin
            errors++; $display("FAIL rw_write: got strobes=%b wdata=%h exp 100/80000100",
                {c_wen, c_ecall, c_mret}, c_wdata);
        end
        checks++;
        if (c_valid !== 1'b1 || c_rd_wen !== 1'b1 || c_rd_data !== 32'h0 ||
            c_redirect !== 1'b0 || c_strobe_resp !== 1'b0) begin
            errors++; $display("FAIL rw_resp: got v=%b wen=%b data=%h redir=%b strobe=%b exp 1/1/0/0/0",
                c_valid, c_rd_wen, c_rd_data, c_redirect, c_strobe_resp);
        end
        checks++;
        if (c_valid_after !== 1'b0 || c_ready_after !== 1'b1) begin
            errors++; $display("FAIL rw_done: got valid=%b ready=%b exp 0/1", c_valid_after, c_ready_after);
        end
    endtask

    task automatic test_csrrs_csrrc();
        m_mstatus = 32'h1800;
        run_req(3'd2, 12'h300, 32'h8, 1'b0, 32'h8000_0004);
        checks++;
        if (c_wen !== 1'b1 || c_wdata !== 32'h1808 || c_rd_data !== 32'h1800) begin
            errors++; $display("FAIL rs: got wen=%b wdata=%h rd=%h exp 1/1808/1800", c_wen, c_wdata, c_rd_data);
        end
        run_req(3'd2, 12'h300, 32'h8, 1'b1, 32'h8000_0008);
        checks++;
        if ({c_wen, c_ecall, c_mret} !== 3'b000 || c_rd_data !== 32'h1800 || c_rd_wen !== 1'b1) begin
            errors++; $display("FAIL rs_zero: got strobes=%b rd=%h rdwen=%b exp 000/1800/1",
                {c_wen, c_ecall, c_mret}, c_rd_data, c_rd_wen);
        end
        m_mstatus = 32'h1808;
        run_req(3'd3, 12'h300, 32'h0000_0808, 1'b0, 32'h8000_000c);
        checks++;
        if (c_wen !== 1'b1 || c_wdata !== 32'h1000 || c_rd_data !== 32'h1808) begin
            errors++; $display("FAIL rc: got wen=%b wdata=%h rd=%h exp 1/1000/1808", c_wen, c_wdata, c_rd_data);
        end
    endtask

    task automatic test_ecall_mret();
        m_mtvec = 32'h8000_1000;
        run_req(3'd4, 12'h000, 32'h0, 1'b1, 32'h8000_0040);
        checks++;
        if (c_rd_addr !== 12'h305 || {c_wen, c_ecall, c_mret} !== 3'b010 ||
            c_mepc !== 32'h8000_0040 || c_mcause !== 32'd11) begin
            errors++; $display("FAIL ecall_write: got addr=%h strobes=%b mepc=%h mcause=%h exp 305/010/80000040/b",
                c_rd_addr, {c_wen, c_ecall, c_mret}, c_mepc, c_mcause);
        end
        checks++;
        if (c_redirect !== 1'b1 || c_redirect_pc !== 32'h8000_1000 || c_rd_wen !== 1'b0) begin
            errors++; $display("FAIL ecall_resp: got redir=%b pc=%h rdwen=%b exp 1/80001000/0",
                c_redirect, c_redirect_pc, c_rd_wen);
        end
        m_mepc = 32'h8000_0044;
        run_req(3'd5, 12'h000, 32'h0, 1'b1, 32'h8000_1010);
        checks++;
        if (c_rd_addr !== 12'h341 || {c_wen, c_ecall, c_mret} !== 3'b001) begin
            errors++; $display("FAIL mret_write: got addr=%h strobes=%b exp 341/001", c_rd_addr, {c_wen, c_ecall, c_mret});
        end
        checks++;
        if (c_redirect !== 1'b1 || c_redirect_pc !== 32'h8000_0044 || c_rd_wen !== 1'b0) begin
            errors++; $display("FAIL mret_resp: got redir=%b pc=%h rdwen=%b exp 1/80000044/0",
                c_redirect, c_redirect_pc, c_rd_wen);
        end
    endtask

    task automatic test_none_ops();
        for (int k = 0; k < 3; k++) begin
            valid_i = 1'b1; ready_i = 1'b1;
            op_i = (k == 0) ? 3'd0 : ((k == 1) ? 3'd6 : 3'd7);
            csr_addr_i = 12'h300; rs1_val_i = 32'hffff_ffff; rs1_zero_i = 1'b0;
            step();
            valid_i = 1'b0; op_i = 3'd0;
            checks++;
            if (ready_o !== 1'b1 || csr_addr_o === 12'h300) begin
                errors++; $display("FAIL none_op%0d: got ready=%b addr=%h exp ready 1, no read started",
                    k, ready_o, csr_addr_o);
            end
            step(); step();
            checks++;
            if (csr_wen_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++; $display("FAIL none_op%0d_quiet: got wen=%b valid=%b exp 0/0", k, csr_wen_o, valid_o);
            end
        end
    endtask

    task automatic test_stall();
        m_mstatus = 32'h0000_0088;
        valid_i = 1'b1; op_i = 3'd1; csr_addr_i = 12'h300;
        rs1_val_i = 32'h1; rs1_zero_i = 1'b0; pc_i = 32'h8000_0100; ready_i = 1'b0;
        step();
        op_i = 3'd2; rs1_val_i = 32'hf0;
        step(); step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (valid_o !== 1'b1 || rd_wen_o !== 1'b1 || rd_data_o !== 32'h88 ||
                ready_o !== 1'b0 || csr_wen_o !== 1'b0) begin
                errors++; $display("FAIL stall_%0d: got v=%b wen=%b rd=%h ready=%b cwen=%b exp 1/1/88/0/0",
                    k, valid_o, rd_wen_o, rd_data_o, ready_o, csr_wen_o);
            end
            step();
        end
        valid_i = 1'b0; op_i = 3'd0;
        ready_i = 1'b1;
        step();
        checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL stall_release: got valid=%b ready=%b exp 0/1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset_mid();
        m_mstatus = 32'h0;
        valid_i = 1'b1; op_i = 3'd1; csr_addr_i = 12'h300;
        rs1_val_i = 32'h55; rs1_zero_i = 1'b0; pc_i = 32'h8000_0200; ready_i = 1'b1;
        step();
        valid_i = 1'b0; op_i = 3'd0;
        step();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({csr_wen_o, csr_ecall_o, csr_mret_o} !== 3'b000) begin
            errors++; $display("FAIL rst_write_strobe: got %b exp 000", {csr_wen_o, csr_ecall_o, csr_mret_o});
        end
        step();
        rst_i = 1'b0;
        checks++;
        if ({valid_o, rd_wen_o, redirect_o, csr_wen_o, csr_ecall_o, csr_mret_o} !== 6'b0 ||
            csr_wdata_o !== 32'h0 || csr_addr_o !== 12'h0 || rd_data_o !== 32'h0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_after: got v=%b wen=%b wdata=%h addr=%h ready=%b exp 0/0/0/0/1",
                valid_o, csr_wen_o, csr_wdata_o, csr_addr_o, ready_o);
        end
    endtask

    task automatic test_unknown_csr();
        m_mtvec = 32'h8000_2000;
        run_req(3'd1, 12'h7c0, 32'h1234, 1'b0, 32'h8000_0300);
`ifdef YSYX_23060251_ILLEGAL_CSR_EN
        checks++;
        if ({c_wen, c_ecall, c_mret} !== 3'b010 || c_mcause !== 32'd2 || c_mepc !== 32'h8000_0300) begin
            errors++; $display("FAIL illegal_write: got strobes=%b mcause=%h mepc=%h exp 010/2/80000300",
                {c_wen, c_ecall, c_mret}, c_mcause, c_mepc);
        end
        checks++;
        if (c_redirect !== 1'b1 || c_redirect_pc !== 32'h8000_2000 || c_rd_wen !== 1'b0) begin
            errors++; $display("FAIL illegal_resp: got redir=%b pc=%h rdwen=%b exp 1/80002000/0",
                c_redirect, c_redirect_pc, c_rd_wen);
        end
`else
        checks++;
        if ({c_wen, c_ecall, c_mret} !== 3'b000 || c_rd_addr !== 12'h7c0) begin
            errors++; $display("FAIL unknown_write: got strobes=%b addr=%h exp 000/7c0",
                {c_wen, c_ecall, c_mret}, c_rd_addr);
        end
        checks++;
        if (c_rd_wen !== 1'b1 || c_rd_data !== 32'h0 || c_redirect !== 1'b0) begin
            errors++; $display("FAIL unknown_resp: got rdwen=%b rd=%h redir=%b exp 1/0/0",
                c_rd_wen, c_rd_data, c_redirect);
        end
`endif
    endtask

    initial begin
        m_mstatus = 32'h0; m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
        test_reset();
        test_csrrw();
        test_csrrs_csrrc();
        test_ecall_mret();
        test_none_ops();
        test_stall();
        test_reset_mid();
        test_unknown_csr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_ctrl.md
Name: csr_ctrl

Overview:
- Sequencer between the execute stage and the machine-mode CSR file.
- Accepts one system instruction per handshake: CSRRW, CSRRS, CSRRC, ECALL or MRET.
- Runs a fixed read–modify–write sequence: reads the old CSR value, then drives the CSR file's write, ecall and mret strobes for exactly one cycle.
- Returns the rd writeback value and any PC redirect to the writeback stage over a valid/ready handshake.

Parameters:
- XLEN, 32, data/PC width.
- MCAUSE_ECALL, 32'd11, mcause value written on ECALL from M-mode.
- MCAUSE_ILLEGAL, 32'd2, mcause value written on an illegal CSR access (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  request valid from the execute stage.
- ready_o  out  1  request accepted; high only in IDLE.
- op_i  in  3  operation: 0 NONE, 1 CSRRW, 2 CSRRS, 3 CSRRC, 4 ECALL, 5 MRET.
- csr_addr_i  in  12  CSR address.
- rs1_val_i  in  XLEN  source operand.
- rs1_zero_i  in  1  rs1 index is x0.
- pc_i  in  XLEN  PC of the instruction.
- csr_rdata_i  in  XLEN  combinational read data from the CSR file.
- csr_addr_o  out  12  CSR address (imm) to the CSR file.
- csr_wdata_o  out  XLEN  write data (src1) to the CSR file.
- csr_wen_o  out  1  CSR write strobe.
- csr_ecall_o  out  1  ecall strobe.
- csr_mret_o  out  1  mret strobe.
- csr_mepc_o  out  XLEN  mepc value for ecall.
- csr_mcause_o  out  XLEN  mcause value for ecall.
- valid_o  out  1  response valid.
- ready_i  in  1  response accepted by the writeback stage.
- rd_wen_o  out  1  rd write enable.
- rd_data_o  out  XLEN  old CSR value for rd.
- redirect_o  out  1  PC redirect request.
- redirect_pc_o  out  XLEN  redirect target.

Behaviour:
- **Reset.** State returns to IDLE. All strobes, valid_o, rd_wen_o and redirect_o are 0. All data outputs are 0. Reset wins over any handshake in the same cycle. Reset mid-sequence aborts with no CSR write issued.
- **FSM states:** IDLE → READ → WRITE → RESP → IDLE.
- **IDLE.** ready_o=1. When valid_i && op_i!=NONE, latch op, addr, rs1, rs1_zero and pc, then go to READ. A request with op_i==NONE is consumed silently and the FSM stays in IDLE.
- **READ** (1 cycle), all strobes low.
  - csr_addr_o is set by op: the latched addr for CSR ops; 0x305 (mtvec) for ECALL; 0x341 (mepc) for MRET.
  - csr_rdata_i is captured into an old-value register.
- **WRITE** (1 cycle). Behaviour by op:
  - CSRRW: csr_wen_o=1, wdata=rs1.
  - CSRRS: wdata = old | rs1.
  - CSRRC: wdata = old & ~rs1.
  - CSRRS/CSRRC with rs1_zero: csr_wen_o=0.
  - ECALL: csr_ecall_o=1, csr_mepc_o=pc, csr_mcause_o=MCAUSE_ECALL.
  - MRET: csr_mret_o=1.
  - Exactly one strobe is high, and only in this cycle.
- **RESP.** valid_o=1, held stable until ready_i. Leave to IDLE on valid_o && ready_i.
  - CSR ops: rd_wen_o=1, rd_data_o=old, redirect_o=0.
  - ECALL/MRET: rd_wen_o=0, redirect_o=1, redirect_pc_o=old (mtvec or mepc).
- **Latency.** Accept at cycle N, write at N+2, earliest response at N+3, next accept at N+4. Throughput is one request per 4 cycles minimum.
- **Boundary cases.**
  - ready_i stalled: all outputs hold and no new request is accepted.
  - Unsupported op_i codes 6–7 are treated as NONE.

Optional Feature:
- Macro: YSYX_23060251_ILLEGAL_CSR_EN.
- **Defined.**
  - A CSR op whose address is not one of 0x300, 0x305, 0x341, 0x342 is converted into a trap.
  - WRITE asserts csr_ecall_o with csr_mepc_o=pc and csr_mcause_o=MCAUSE_ILLEGAL.
  - RESP gives redirect_o=1 with redirect_pc_o=mtvec, read in READ, and rd_wen_o=0.
- **Undefined.** Unknown addresses complete normally: csr_wen_o is forced to 0, and rd_data_o=0 because the CSR file returns 0.

Decomposition:
- **Shared defines:** op encodings, CSR addresses, state encoding, XLEN, MCAUSE constants, in the existing ysyx_23060251 define set.
- **Sub-module:** one combinational helper, csr_alu, computing wdata from op, old and rs1. The FSM stays in csr_ctrl.

Test Plan:
- CSRRW 0x305, rs1=0x8000_0100, old=0: wen pulses at N+2 with wdata 0x8000_0100; RESP gives rd_data=0, rd_wen=1.
- CSRRS 0x300, old=0x1800, rs1=0x8: wdata=0x1808, rd_data=0x1800. Repeating with rs1_zero=1 gives no wen pulse and the same rd_data.
- ECALL at pc=0x8000_0040, mtvec=0x8000_1000: ecall pulse with mepc=0x8000_0040 and mcause=11; redirect to 0x8000_1000; rd_wen=0.
- MRET with mepc=0x8000_0044: mret pulse; redirect to 0x8000_0044.
- ready_i low for 5 cycles in RESP: outputs stable, ready_o=0. rst_i asserted in WRITE gives no strobe, and all outputs are 0 the next cycle.
- CSRRW 0x7C0: with the macro, ecall pulse with mcause=2 and redirect to mtvec; without it, no wen and rd_data=0.
